sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester and the data requester.
- The data requester is the one serving the memory stage's load/store accesses.
- Arbitrates requests, holds the grant stable until address acceptance, and tracks outstanding transactions in an in-order owner FIFO.
- Routes each data_ok/rdata back to the requester that issued the transaction.
- Sits between the pipeline's inst/data sram-like interfaces and the downstream memory/bus bridge.

Parameters:
- DEPTH, 2, maximum outstanding accepted transactions (owner FIFO depth, power of 2, >=1).
- STARVE_LIMIT, 4, consecutive cycles inst_req may lose arbitration before it receives priority for one grant.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- inst_req  in  1  instruction requester request.
- inst_wr  in  1  write flag (always 0 in practice, still forwarded).
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_addr  in  32  request address.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  inst request accepted this cycle.
- inst_data_ok  out  1  inst response valid this cycle.
- inst_rdata  out  32  inst read data.
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data requester, same meaning as inst_*.
- data_addr_ok, data_data_ok  out  1/1  data handshakes.
- data_rdata  out  32  data read data.
- mem_req, mem_wr  out  1/1  to memory port.
- mem_size  out  2  to memory port.
- mem_addr, mem_wdata  out  32/32  to memory port.
- mem_addr_ok, mem_data_ok  in  1/1  from memory port.
- mem_rdata  in  32  from memory port.
- protocol_err  out  1  sticky; set when mem_data_ok arrives with no outstanding transaction.

Behaviour:
- Reset: owner FIFO empty (count=0, rd/wr ptr=0), lock=0, starve_cnt=0, protocol_err=0. All handshake outputs are 0 during and after reset while no request is active.
- Grant (combinational) is evaluated in this order:
  - lock=1: grant=lock_owner.
  - starve_cnt==STARVE_LIMIT and inst_req: grant inst.
  - data_req: grant data.
  - inst_req: grant inst.
  - Otherwise no grant.
- mem_req = granted requester's req && !full, where full = count==DEPTH. full blocks issue even if a pop occurs the same cycle.
- mem_wr/size/addr/wdata mux from the granted requester. When there is no grant they carry the data requester's fields.
- addr_ok routing: inst_addr_ok = mem_req && mem_addr_ok && grant==inst; data_addr_ok likewise for data. The non-granted requester never sees addr_ok.
- Lock rules:
  - mem_req && !mem_addr_ok: lock<=1, lock_owner<=grant. Requests must stay stable; sram-like masters do not withdraw req.
  - mem_req && mem_addr_ok: lock<=0.
- Push: on mem_req && mem_addr_ok, write owner id (0=inst, 1=data) at wr_ptr; wr_ptr++ modulo DEPTH; count++.
- Pop: on mem_data_ok && count!=0, read owner at rd_ptr, raise that requester's data_ok the same cycle (combinational from the FIFO head); rd_ptr++; count--.
- rdata: inst_rdata and data_rdata are both driven from mem_rdata directly. Only the data_ok qualifies them.
- Simultaneous push and pop: count unchanged, both pointers advance.
- mem_data_ok with count==0: no data_ok to either side, FIFO unchanged, protocol_err<=1 (cleared only by reset).
- Responses are in order. The memory port never returns data_ok in the same cycle as the addr_ok of the same transaction, so the head is always valid when data_ok arrives.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) in each cycle inst_req=1 && lock=0 && grant==data && !full.
  - Resets to 0 on inst handshake or when inst_req=0.
- Reset mid-operation: all outstanding owners are discarded. Later data_ok from the memory port before a new issue sets protocol_err (system resets both together, so this is not expected in practice).
- Latency: zero added cycles. Request to mem_req and data_ok to requester are both combinational paths.

Test Plan:
- Single data read, mem_addr_ok same cycle, data_ok 2 cycles later, rdata=0x1234_5678 -> data_addr_ok pulses once, data_data_ok pulses with data_rdata=0x1234_5678, inst_* handshakes stay 0, count returns 0.
- inst_req and data_req both high, no lock -> data granted first (mem_addr=data_addr). Next cycle inst is granted, and responses route data then inst in order.
- Data wins, mem_addr_ok held low 3 cycles while inst_req stays high -> mem_addr stays data_addr for all 3 cycles (lock), and inst_addr_ok=0 until the data handshake completes.
- DEPTH=2: issue 2 inst reads with no data_ok -> mem_req drops to 0 (full) with a third inst_req pending. data_ok then returns two words to inst in order, after which the third request issues.
- Continuous data_req with inst_req, STARVE_LIMIT=4 -> after 4 losing cycles inst is granted exactly once, then data priority resumes.
- mem_data_ok pulse with nothing outstanding -> no data_ok on either side, protocol_err=1 and it stays 1 until reset.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like port arbiter: data requester normally wins, inst gets a
// guaranteed grant after STARVE_LIMIT lost cycles; responses routed via in-order owner FIFO.
module sram_like_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        protocol_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {GrantNone, GrantInst, GrantData} grant_e;

    grant_e grant;

    logic             owner_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lock_q, lock_d;
    logic             lock_owner_q, lock_owner_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             perr_q, perr_d;

    logic full;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    always_comb begin
        grant = GrantNone;
        if (lock_q) begin
            grant = (lock_owner_q == OWNER_DATA) ? GrantData : GrantInst;
        end else if (starve_q == STV_W'(STARVE_LIMIT) && inst_req) begin
            grant = GrantInst;
        end else if (data_req) begin
            grant = GrantData;
        end else if (inst_req) begin
            grant = GrantInst;
        end
    end

    // A pop in the same cycle does not free a slot for issue.
    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        unique case (grant)
            GrantInst: begin
                mem_req   = inst_req && !full;
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
            GrantData: mem_req = data_req && !full;
            default:   mem_req = 1'b0;
        endcase
    end

    assign push = mem_req && mem_addr_ok;
    assign pop  = mem_data_ok && (count_q != '0);
    assign head = owner_q[rd_ptr_q];

    assign inst_addr_ok = push && (grant == GrantInst);
    assign data_addr_ok = push && (grant == GrantData);
    assign inst_data_ok = pop && (head == OWNER_INST);
    assign data_data_ok = pop && (head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign protocol_err = perr_q;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        starve_d     = starve_q;
        perr_d       = perr_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (mem_req && !mem_addr_ok) begin
            lock_d       = 1'b1;
            lock_owner_d = (grant == GrantData) ? OWNER_DATA : OWNER_INST;
        end else if (mem_req && mem_addr_ok) begin
            lock_d = 1'b0;
        end

        if (!inst_req || inst_addr_ok) begin
            starve_d = '0;
        end else if (!lock_q && grant == GrantData && !full &&
                     starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end

        if (mem_data_ok && count_q == '0) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INST;
            starve_q     <= '0;
            perr_q       <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
            perr_q       <= perr_d;
        end
    end

    // Owner slots need no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            owner_q[wr_ptr_q] <= (grant == GrantData) ? OWNER_DATA : OWNER_INST;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter against a queue-based reference model
// of the arbitration, lock, starvation and response-routing rules.
module tb_sram_like_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        protocol_err;

    sram_like_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owners of accepted transactions in issue order (1 = data).
    bit model_q[$];
    bit lock_m;
    bit lock_who;
    int starve_m;
    bit perr_m;

    bit inst_pend, data_pend;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset       = 1'b1;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        inst_pend   = 1'b0;
        data_pend   = 1'b0;
        model_q.delete();
        lock_m   = 1'b0;
        lock_who = 1'b0;
        starve_m = 0;
        perr_m   = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        check_val("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        check_val("rst_perr", protocol_err, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("idle_mem_req", mem_req, 0);
        check_val("idle_handshakes",
                  {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    endtask

    // One cycle: drive at negedge, check just after, then advance the model to the next edge.
    task automatic step(input int irate, input int drate, input int aok_rate,
                        input int dok_rate, input bit spurious);
        int  gnt;
        bit  full, greq, e_req, e_push, e_pop, head;
        logic [66:0] e_fields;
        @(negedge clk);
        if (!inst_pend) begin
            inst_wr    = ($urandom_range(9) == 0);
            inst_size  = 2'($urandom_range(2));
            inst_addr  = $urandom;
            inst_wdata = $urandom;
            if ($urandom_range(99) < irate) inst_pend = 1'b1;
        end
        if (!data_pend) begin
            data_wr    = $urandom_range(1);
            data_size  = 2'($urandom_range(2));
            data_addr  = $urandom;
            data_wdata = $urandom;
            if ($urandom_range(99) < drate) data_pend = 1'b1;
        end
        inst_req    = inst_pend;
        data_req    = data_pend;
        mem_addr_ok = ($urandom_range(99) < aok_rate);
        mem_rdata   = $urandom;
        if (model_q.size() > 0) mem_data_ok = ($urandom_range(99) < dok_rate);
        else                    mem_data_ok = spurious && ($urandom_range(99) < dok_rate);
        #1;

        full = (model_q.size() >= DEPTH);
        if (lock_m)                                  gnt = lock_who ? 2 : 1;
        else if (starve_m == STARVE_LIMIT && inst_req) gnt = 1;
        else if (data_req)                           gnt = 2;
        else if (inst_req)                           gnt = 1;
        else                                         gnt = 0;
        greq     = (gnt == 1) ? inst_req : (gnt == 2) ? data_req : 1'b0;
        e_req    = greq && !full;
        e_fields = (gnt == 1) ? {inst_wr, inst_size, inst_addr, inst_wdata}
                              : {data_wr, data_size, data_addr, data_wdata};
        e_push   = e_req && mem_addr_ok;
        e_pop    = mem_data_ok && (model_q.size() > 0);
        head     = e_pop ? model_q[0] : 1'b0;

        check_val("mem_req", mem_req, e_req);
        check_val("mem_fields", {mem_wr, mem_size, mem_addr, mem_wdata}, e_fields);
        check_val("inst_addr_ok", inst_addr_ok, e_push && gnt == 1);
        check_val("data_addr_ok", data_addr_ok, e_push && gnt == 2);
        check_val("inst_data_ok", inst_data_ok, e_pop && !head);
        check_val("data_data_ok", data_data_ok, e_pop && head);
        check_val("protocol_err", protocol_err, perr_m);
        if (inst_data_ok) check_val("inst_rdata", inst_rdata, mem_rdata);
        if (data_data_ok) check_val("data_rdata", data_rdata, mem_rdata);

        if (!inst_req || (e_push && gnt == 1)) starve_m = 0;
        else if (!lock_m && gnt == 2 && !full && starve_m < STARVE_LIMIT) starve_m++;
        if (e_req && !mem_addr_ok) begin
            lock_m   = 1'b1;
            lock_who = (gnt == 2);
        end else if (e_push) begin
            lock_m = 1'b0;
        end
        if (mem_data_ok && model_q.size() == 0) perr_m = 1'b1;
        if (e_pop) void'(model_q.pop_front());
        if (e_push) model_q.push_back(gnt == 2);
        if (e_push && gnt == 1) inst_pend = 1'b0;
        if (e_push && gnt == 2) data_pend = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        inst_req    = 1'b0;
        inst_wr     = 1'b0;
        inst_size   = 2'd2;
        inst_addr   = '0;
        inst_wdata  = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_addr   = '0;
        data_wdata  = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;

        do_reset(3);
        repeat (1500) step(40, 40, 60, 50, 1'b0);
        // Both requesters always busy with a fast memory: exercises starvation grants.
        repeat (800)  step(100, 100, 90, 80, 1'b0);
        // Slow memory: long locks and a full owner FIFO.
        repeat (800)  step(70, 70, 25, 20, 1'b0);
        // Spurious data_ok with nothing outstanding; the error flag must stick.
        repeat (300)  step(30, 30, 70, 30, 1'b1);
        repeat (200)  step(50, 50, 60, 40, 1'b0);
        // Reset while transactions are outstanding.
        repeat (50)   step(80, 80, 50, 10, 1'b0);
        do_reset(2);
        repeat (800)  step(50, 60, 50, 50, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
